// File: rtl/lemmings_pkg.sv
// ---------------------------------------------------------------------------
// lemmings_pkg
// Shared definitions for the lemmings array:
//   lem_state_e    - per-channel FSM state encoding
//   fall_cnt_width - width of the fall counter. It must hold SPLAT_CYCLES+1
//                    because the counter saturates there.
// ---------------------------------------------------------------------------
package lemmings_pkg;

   typedef enum logic [2:0] {
      WALK_L = 3'd0,
      WALK_R = 3'd1,
      FALL_L = 3'd2,
      FALL_R = 3'd3,
      DIG_L  = 3'd4,
      DIG_R  = 3'd5,
      SPLAT  = 3'd6
   } lem_state_e;

   function automatic int fall_cnt_width(input int splat_cycles);
      return $clog2(splat_cycles + 2);
   endfunction

endpackage

// File: rtl/lemming_fsm.sv
// ---------------------------------------------------------------------------
// lemming_fsm
// Moore FSM for one lemming channel, with a saturating fall counter.
//
// Ports:
//   clk, areset_n      - clock and asynchronous active-low reset
//   bump_left/right    - obstacle on either side
//   ground             - 1 when ground is present under the lemming
//   dig                - dig command
//   walk_left/right    - walking direction outputs
//   aaah               - falling
//   digging            - digging
//   alive              - 1 in every state except SPLAT
// ---------------------------------------------------------------------------
module lemming_fsm
   import lemmings_pkg::*;
#(
   parameter int SPLAT_CYCLES = 20
) (
   input  logic clk,
   input  logic areset_n,
   input  logic bump_left,
   input  logic bump_right,
   input  logic ground,
   input  logic dig,
   output logic walk_left,
   output logic walk_right,
   output logic aaah,
   output logic digging,
   output logic alive
);

   localparam int CW = fall_cnt_width(SPLAT_CYCLES);
   localparam logic [CW-1:0] SPLAT_LIM = CW'(SPLAT_CYCLES);
   localparam logic [CW-1:0] CNT_MAX   = CW'(SPLAT_CYCLES + 1);

   lem_state_e    state_q, state_d;
   logic [CW-1:0] fall_cnt_q, fall_cnt_d;
   logic          falling_now, falling_next;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q    <= WALK_L;
         fall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fall_cnt_q <= fall_cnt_d;
      end
   end

   // Next-state logic. The counter holds the number of fall cycles already
   // completed, so counter+1 > SPLAT_CYCLES reduces to counter >= SPLAT_CYCLES.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WALK_L: begin
            if (!ground)        state_d = FALL_L;
            else if (dig)       state_d = DIG_L;
            else if (bump_left) state_d = WALK_R;
         end
         WALK_R: begin
            if (!ground)         state_d = FALL_R;
            else if (dig)        state_d = DIG_R;
            else if (bump_right) state_d = WALK_L;
         end
         FALL_L: begin
            if (ground) state_d = (fall_cnt_q >= SPLAT_LIM) ? SPLAT : WALK_L;
         end
         FALL_R: begin
            if (ground) state_d = (fall_cnt_q >= SPLAT_LIM) ? SPLAT : WALK_R;
         end
         DIG_L: begin
            if (!ground) state_d = FALL_L;
         end
         DIG_R: begin
            if (!ground) state_d = FALL_R;
         end
         SPLAT:   state_d = SPLAT;
         default: state_d = WALK_L;
      endcase
   end

   // The counter only advances while the lemming stays in a fall state. Any
   // other state, including the entry into a fall, starts it again from zero.
   always_comb begin
      falling_now  = (state_q == FALL_L) || (state_q == FALL_R);
      falling_next = (state_d == FALL_L) || (state_d == FALL_R);
      fall_cnt_d   = '0;
      if (falling_now && falling_next) begin
         fall_cnt_d = (fall_cnt_q == CNT_MAX) ? fall_cnt_q : fall_cnt_q + CW'(1);
      end
   end

   always_comb begin
      walk_left  = 1'b0;
      walk_right = 1'b0;
      aaah       = 1'b0;
      digging    = 1'b0;
      alive      = (state_q != SPLAT);
      unique case (state_q)
         WALK_L:         walk_left  = 1'b1;
         WALK_R:         walk_right = 1'b1;
         FALL_L, FALL_R: aaah       = 1'b1;
         DIG_L, DIG_R:   digging    = 1'b1;
         default:        ;
      endcase
   end

endmodule

// File: rtl/lemmings_array.sv
// ---------------------------------------------------------------------------
// lemmings_array
// Array of N_LEM independent lemming FSMs plus a count of live lemmings.
//
// Ports (each bus carries one bit per channel):
//   clk, areset_n           - clock and asynchronous active-low reset
//   bump_left, bump_right   - obstacle inputs
//   ground, dig             - ground-present and dig-command inputs
//   walk_left, walk_right   - walking direction outputs
//   aaah, digging           - falling and digging outputs
//   alive_count             - number of channels not in SPLAT
// ---------------------------------------------------------------------------
module lemmings_array
   import lemmings_pkg::*;
#(
   parameter int N_LEM        = 4,
   parameter int SPLAT_CYCLES = 20
) (
   input  logic                       clk,
   input  logic                       areset_n,
   input  logic [N_LEM-1:0]           bump_left,
   input  logic [N_LEM-1:0]           bump_right,
   input  logic [N_LEM-1:0]           ground,
   input  logic [N_LEM-1:0]           dig,
   output logic [N_LEM-1:0]           walk_left,
   output logic [N_LEM-1:0]           walk_right,
   output logic [N_LEM-1:0]           aaah,
   output logic [N_LEM-1:0]           digging,
   output logic [$clog2(N_LEM+1)-1:0] alive_count
);

   localparam int AW = $clog2(N_LEM + 1);

   logic [N_LEM-1:0] alive_vec;

   for (genvar g = 0; g < N_LEM; g++) begin : g_lem
      lemming_fsm #(
         .SPLAT_CYCLES(SPLAT_CYCLES)
      ) u_fsm (
         .clk       (clk),
         .areset_n  (areset_n),
         .bump_left (bump_left[g]),
         .bump_right(bump_right[g]),
         .ground    (ground[g]),
         .dig       (dig[g]),
         .walk_left (walk_left[g]),
         .walk_right(walk_right[g]),
         .aaah      (aaah[g]),
         .digging   (digging[g]),
         .alive     (alive_vec[g])
      );
   end

   // Population count of the live channels. It is purely combinational, so
   // it tracks the registered states with no extra cycle of delay.
   always_comb begin
      alive_count = '0;
      for (int i = 0; i < N_LEM; i++) begin
         alive_count = alive_count + AW'(alive_vec[i]);
      end
   end

endmodule

// File: tb/tb_lemmings_array.sv
// ---------------------------------------------------------------------------
// tb_lemmings_array
// Directed bench for lemmings_array. The stimulus process drives one input
// vector per cycle on the falling edge and queues the hand-determined
// expected outputs. A monitor samples just after each rising edge and checks
// the outputs against the head of the queue.
// ---------------------------------------------------------------------------
module tb_lemmings_array;

   localparam int N_LEM = 4;

   logic       clk = 1'b0;
   logic       areset_n;
   logic [3:0] bump_left, bump_right, ground, dig;
   logic [3:0] walk_left, walk_right, aaah, digging;
   logic [2:0] alive_count;

   typedef enum int {E_WL, E_WR, E_FALL, E_DIG, E_DEAD} exp_e;

   typedef struct {
      logic [3:0] wl;
      logic [3:0] wr;
      logic [3:0] aa;
      logic [3:0] dg;
      logic [2:0] alive;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   exp_e ch_exp[N_LEM];
   int   n_checks = 0;
   int   n_fail   = 0;

   lemmings_array #(
      .N_LEM       (4),
      .SPLAT_CYCLES(20)
   ) dut (
      .clk        (clk),
      .areset_n   (areset_n),
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .ground     (ground),
      .dig        (dig),
      .walk_left  (walk_left),
      .walk_right (walk_right),
      .aaah       (aaah),
      .digging    (digging),
      .alive_count(alive_count)
   );

   always #5 clk = ~clk;

   // Turns the hand-chosen per-channel behaviour into the output vectors
   // that behaviour should produce.
   function automatic exp_t build_exp(input string tag);
      exp_t e;
      e.wl    = '0;
      e.wr    = '0;
      e.aa    = '0;
      e.dg    = '0;
      e.alive = '0;
      e.tag   = tag;
      for (int i = 0; i < N_LEM; i++) begin
         case (ch_exp[i])
            E_WL:    e.wl[i] = 1'b1;
            E_WR:    e.wr[i] = 1'b1;
            E_FALL:  e.aa[i] = 1'b1;
            E_DIG:   e.dg[i] = 1'b1;
            default: ;
         endcase
         if (ch_exp[i] != E_DEAD) e.alive = e.alive + 3'd1;
      end
      return e;
   endfunction

   task automatic checkOutput(input exp_t e);
      n_checks++;
      if ({walk_left, walk_right, aaah, digging, alive_count} !==
          {e.wl, e.wr, e.aa, e.dg, e.alive}) begin
         n_fail++;
         $display("[TB] FAIL %s: got wl=%b wr=%b aaah=%b dig=%b alive=%0d, expected wl=%b wr=%b aaah=%b dig=%b alive=%0d",
                  e.tag, walk_left, walk_right, aaah, digging, alive_count,
                  e.wl, e.wr, e.aa, e.dg, e.alive);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] b_l, input logic [3:0] b_r,
                                input logic [3:0] gnd, input logic [3:0] dg,
                                input string tag);
      @(negedge clk);
      bump_left  = b_l;
      bump_right = b_r;
      ground     = gnd;
      dig        = dg;
      exp_q.push_back(build_exp(tag));
   endtask

   // Monitor: one check per rising edge whenever an expectation is queued.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      areset_n   = 1'b0;
      bump_left  = '0;
      bump_right = '0;
      ground     = 4'hF;
      dig        = '0;
      for (int i = 0; i < N_LEM; i++) ch_exp[i] = E_WL;

      #12;
      checkOutput(build_exp("reset_hold"));
      @(negedge clk);
      areset_n = 1'b1;

      // ch0 bump on the facing side turns it right; others keep walking left
      ch_exp[0] = E_WR;
      applyStimulus(4'b0001, 4'b0000, 4'hF, 4'b0000, "ch0_bump_left");
      applyStimulus(4'b0000, 4'b0000, 4'hF, 4'b0000, "ch0_walks_right");

      // ch1 falls for exactly 20 cycles and survives
      ch_exp[1] = E_FALL;
      for (int k = 0; k < 20; k++)
         applyStimulus(4'b0000, 4'b0000, 4'b1101, 4'b0000, "ch1_fall20");
      ch_exp[1] = E_WL;
      applyStimulus(4'b0000, 4'b0000, 4'hF, 4'b0000, "ch1_land20");

      // ch2 turns right, digs in preference to a bump, falls, lands right
      ch_exp[2] = E_WR;
      applyStimulus(4'b0100, 4'b0000, 4'hF, 4'b0000, "ch2_turn_right");
      ch_exp[2] = E_DIG;
      applyStimulus(4'b0000, 4'b0100, 4'hF, 4'b0100, "ch2_dig_over_bump");
      applyStimulus(4'b0100, 4'b0100, 4'hF, 4'b0000, "ch2_dig_ignores_bump");
      ch_exp[2] = E_FALL;
      applyStimulus(4'b0000, 4'b0000, 4'b1011, 4'b0000, "ch2_dig_to_fall");
      ch_exp[2] = E_WR;
      applyStimulus(4'b0000, 4'b0000, 4'hF, 4'b0000, "ch2_land_right");

      // ch3 falls even though dig is requested; bumps and dig ignored mid-fall
      ch_exp[3] = E_FALL;
      applyStimulus(4'b0000, 4'b0000, 4'b0111, 4'b1000, "ch3_fall_over_dig");
      applyStimulus(4'b1000, 4'b1000, 4'b0111, 4'b1000, "ch3_fall_ignores");
      ch_exp[3] = E_WL;
      applyStimulus(4'b0000, 4'b0000, 4'hF, 4'b0000, "ch3_land_left");

      // both bumps at once always reverse ch0
      ch_exp[0] = E_WL;
      applyStimulus(4'b0001, 4'b0001, 4'hF, 4'b0000, "ch0_both_bumps_a");
      ch_exp[0] = E_WR;
      applyStimulus(4'b0001, 4'b0001, 4'hF, 4'b0000, "ch0_both_bumps_b");

      // ch1 falls 21 cycles and splats; ch0 turns in the same first cycle
      ch_exp[0] = E_WL;
      ch_exp[1] = E_FALL;
      for (int k = 0; k < 21; k++)
         applyStimulus(4'b0000, (k == 0) ? 4'b0001 : 4'b0000, 4'b1101, 4'b0000,
                       "ch1_fall21");
      ch_exp[1] = E_DEAD;
      applyStimulus(4'b0000, 4'b0000, 4'hF, 4'b0000, "ch1_splat");
      applyStimulus(4'b0010, 4'b0010, 4'hF, 4'b0010, "ch1_dead_ignores");
      applyStimulus(4'b0000, 4'b0000, 4'b1101, 4'b0000, "ch1_dead_no_ground");

      // ch2 mid-fall, ch1 splatted: asynchronous reset revives everything
      ch_exp[2] = E_FALL;
      for (int k = 0; k < 3; k++)
         applyStimulus(4'b0000, 4'b0000, 4'b1011, 4'b0000, "ch2_falling");

      @(negedge clk);
      for (int i = 0; i < N_LEM; i++) ch_exp[i] = E_WL;
      exp_q.push_back(build_exp("reset_sampled"));
      #2;
      areset_n = 1'b0;
      #1;
      checkOutput(build_exp("reset_async"));
      @(negedge clk);
      areset_n = 1'b1;
      ground   = 4'hF;
      exp_q.push_back(build_exp("post_reset"));

      // a fresh one-cycle fall after reset lands safely
      ch_exp[2] = E_FALL;
      applyStimulus(4'b0000, 4'b0000, 4'b1011, 4'b0000, "ch2_refall");
      ch_exp[2] = E_WL;
      applyStimulus(4'b0000, 4'b0000, 4'hF, 4'b0000, "ch2_reland");

      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lemmings_array.md
LEMMINGS_ARRAY -- requirements
Module: lemmings_array

Interface
REQ-001 SHALL have parameter N_LEM, default 4, meaning the number of independent lemming channels (1..32).
REQ-002 SHALL have parameter SPLAT_CYCLES, default 20, meaning the maximum number of fall cycles survivable (1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port areset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port bump_left, input, N_LEM bits: per-channel obstacle on the left.
REQ-006 SHALL have port bump_right, input, N_LEM bits: per-channel obstacle on the right.
REQ-007 SHALL have port ground, input, N_LEM bits: per-channel ground present (1 = ground).
REQ-008 SHALL have port dig, input, N_LEM bits: per-channel dig command.
REQ-009 SHALL have port walk_left, output, N_LEM bits: channel is walking left.
REQ-010 SHALL have port walk_right, output, N_LEM bits: channel is walking right.
REQ-011 SHALL have port aaah, output, N_LEM bits: channel is falling.
REQ-012 SHALL have port digging, output, N_LEM bits: channel is digging.
REQ-013 SHALL have port alive_count, output, $clog2(N_LEM+1) bits: number of channels not in SPLAT.

Function
REQ-014 SHALL run one Moore FSM per channel with states WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT; outputs SHALL be decoded from state only.
REQ-015 SHALL assert, per channel, exactly one of walk_left/walk_right/aaah/digging in non-SPLAT states; all four SHALL be 0 in SPLAT.
REQ-016 SHALL, in WALK_x, apply priority ground=0 -> FALL_x; else dig=1 -> DIG_x; else bump on the facing side -> WALK of the opposite direction; else stay.
REQ-017 SHALL treat bump_left=bump_right=1 in WALK_x as a bump on the facing side (direction reverses).
REQ-018 SHALL ignore bump and dig inputs in FALL_x, DIG_x and SPLAT.
REQ-019 SHALL, in DIG_x, go to FALL_x when ground=0, else stay in DIG_x.
REQ-020 SHALL keep a per-channel fall counter: cleared to 0 in any non-FALL state, incremented each cycle in FALL_x, saturating at SPLAT_CYCLES+1.
REQ-021 SHALL, in FALL_x with ground=1, go to SPLAT if the cycles spent in FALL_x (counter+1) exceed SPLAT_CYCLES, else go to WALK_x (pre-fall direction kept).
REQ-022 SHALL keep SPLAT until reset, regardless of inputs.
REQ-023 SHALL make alive_count a combinational population count of non-SPLAT channels, with zero added latency.
REQ-024 SHALL keep channels fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-025 SHALL, while areset_n=0, force every channel to WALK_L with the fall counter at 0, independent of clk.
REQ-026 SHALL present at reset walk_left=all-ones, walk_right=aaah=digging=0, and alive_count=N_LEM.
REQ-027 SHALL return a channel to WALK_L when reset is asserted mid-fall, mid-dig or in SPLAT.

Structure
REQ-028 SHALL define the state enum and the counter-width function in shared package lemmings_pkg.
REQ-029 SHALL implement one channel as sub-module lemming_fsm, parametrised by SPLAT_CYCLES and instantiated N_LEM times by a generate loop.

Verification
REQ-030 SHALL cover: reset, then ch0 bump_left=1 for 1 cycle -> ch0 walk_right=1 on the next cycle; other channels stay walk_left=1.
REQ-031 SHALL cover: ch1 ground=0 for 20 cycles (default) -> aaah=1 for 20 cycles, then walk_left=1; alive_count stays 4.
REQ-032 SHALL cover: ch1 ground=0 for 21 cycles -> SPLAT, all ch1 outputs 0, alive_count=3; bumps and dig on ch1 are then ignored.
REQ-033 SHALL cover: ch2 walking right, dig=1 with bump_right=1 -> digging=1; ground=0 -> aaah=1; ground=1 -> walk_right=1.
REQ-034 SHALL cover: ch3 in WALK_L with ground=0 and dig=1 together -> aaah=1 (fall has priority over dig).
REQ-035 SHALL cover: areset_n asserted asynchronously mid-fall and after a splat -> all channels walk_left=1 immediately and alive_count=4.
